multi_chan_trigger: RTL and testbench
=====================================

MULTI_CHAN_TRIGGER -- requirements
Module: multi_chan_trigger

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (1..16).
REQ-002 SHALL have parameter HOLDOFF_W, default 16, holdoff counter width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port armed  input  1  level; high enables trigger search.
REQ-006 SHALL have port ch_hi  input  NUM_CH  per channel, 1 = signal above high threshold; already synchronised to clk.
REQ-007 SHALL have port ch_lo  input  NUM_CH  per channel, 1 = signal above low threshold; already synchronised to clk.
REQ-008 SHALL have port ch_cfg  input  5*NUM_CH  per-channel field at [5i+4:5i]: bit0 dont-care, bit1 low level, bit2 high level, bit3 negative edge, bit4 positive edge.
REQ-009 SHALL have port combine_and  input  1  0 = OR across channels, 1 = AND across channels.
REQ-010 SHALL have port holdoff  input  HOLDOFF_W  cycles to wait after arming before searching.
REQ-011 SHALL have port trig_clr  input  1  one-cycle pulse; re-arms after a trigger.
REQ-012 SHALL have port trig_out  output  1  sticky trigger flag.
REQ-013 SHALL have port trig_pulse  output  1  one-cycle pulse on trigger.
REQ-014 SHALL have port trig_src  output  NUM_CH  per-channel qualify vector captured at trigger.
REQ-015 SHALL have port busy  output  1  high in HOLDOFF state.

Function
REQ-016 SHALL register ch_hi/ch_lo into stage s1, then s1 into s2, every cycle regardless of state.
REQ-017 SHALL detect positive edge per channel as s1_hi & ~s2_hi, and negative edge as ~s1_lo & s2_lo.
REQ-018 SHALL capture each detected edge into a per-channel sticky flag, set only in WAIT, held until leaving WAIT/TRIGGERED to IDLE or HOLDOFF.
REQ-019 SHALL compute per-channel qualify: cfg0 | (cfg1 & ~s2_lo) | (cfg2 & s2_hi) | (cfg3 & neg_sticky) | (cfg4 & pos_sticky).
REQ-020 SHALL combine: OR mode = OR of qualify bits; AND mode = AND of qualify bits; a channel with cfg = 0 contributes 0 in both modes.
REQ-021 SHALL implement FSM IDLE, HOLDOFF, WAIT, TRIGGERED.
REQ-022 IDLE: armed=1 -> HOLDOFF, counter loads holdoff; if holdoff=0 -> WAIT directly.
REQ-023 HOLDOFF: counter decrements per cycle; at counter=1 -> WAIT next edge (total holdoff cycles in HOLDOFF).
REQ-024 WAIT: combined=1 -> TRIGGERED; trig_out<=1, trig_pulse<=1 for one cycle, trig_src<=qualify vector, all on same edge.
REQ-025 TRIGGERED: trig_clr=1 -> HOLDOFF with counter reload (or WAIT if holdoff=0), trig_out<=0, stickies cleared; trig_src held until next trigger.
REQ-026 armed=0 in any state -> IDLE next edge; trig_out, trig_pulse, stickies, busy cleared; armed=0 overrides trig_clr.
REQ-027 trig_clr outside TRIGGERED SHALL be ignored.
REQ-028 Latency: input change sampled at edge E0 yields trig_out=1 after edge E2, for both level and edge conditions.
REQ-029 No further trig_pulse while in TRIGGERED, regardless of input activity.
REQ-030 holdoff SHALL be sampled only on counter load; changes mid-count ignored.

Reset
REQ-031 rst_n low SHALL force state IDLE, s1/s2, stickies, counter, trig_out, trig_pulse, trig_src, busy all 0, asynchronously.
REQ-032 After rst_n release with armed=1, SHALL enter HOLDOFF on first clk edge.

Verification
REQ-033 NUM_CH=4, ch0 cfg=pos edge, holdoff=0, arm; ch_hi[0] 0->1 before E0 -> trig_out=1, trig_pulse 1 cycle after E2, trig_src=4'b0001.
REQ-034 holdoff=5, ch1 cfg=high level, ch_hi[1]=1 throughout -> busy high 5 cycles, trigger 2 edges after entering WAIT.
REQ-035 combine_and=1, ch0 high, ch2 neg edge, ch1/ch3 dont-care; only ch0 high -> no trigger; ch_lo[2] 1->0 -> trigger, trig_src=4'b1111.
REQ-036 Edge occurring during HOLDOFF -> not captured, no trigger; same edge after WAIT -> trigger.
REQ-037 In TRIGGERED, pulse trig_clr and armed=0 same cycle -> IDLE, trig_out=0; then trig_clr alone in TRIGGERED -> HOLDOFF reload.
REQ-038 Assert rst_n low mid-HOLDOFF -> all outputs 0 immediately, busy=0 without clk.

Source files
------------

// File: rtl/multi_chan_trigger.sv
`default_nettype none
// multi_chan_trigger: per-channel level/edge qualifiers combined by OR/AND,
// gated by an arm/holdoff/wait/triggered state machine with a sticky trigger.
module multi_chan_trigger #(
  parameter int NUM_CH    = 4,
  parameter int HOLDOFF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   armed,
  input  logic [NUM_CH-1:0]      ch_hi,
  input  logic [NUM_CH-1:0]      ch_lo,
  input  logic [5*NUM_CH-1:0]    ch_cfg,
  input  logic                   combine_and,
  input  logic [HOLDOFF_W-1:0]   holdoff,
  input  logic                   trig_clr,
  output logic                   trig_out,
  output logic                   trig_pulse,
  output logic [NUM_CH-1:0]      trig_src,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLDOFF   = 2'd1,
    S_WAIT      = 2'd2,
    S_TRIGGERED = 2'd3
  } state_t;

  localparam logic [HOLDOFF_W-1:0] c_one = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [HOLDOFF_W-1:0]  r_cnt;
  logic [NUM_CH-1:0]     r_s1_hi, r_s1_lo, r_s2_hi, r_s2_lo;
  logic [NUM_CH-1:0]     r_pos_sticky, r_neg_sticky;
  logic [NUM_CH-1:0]     w_pos, w_neg, w_qual;
  logic                  w_combined;
  logic                  w_load;
  logic                  w_fire;
  logic                  w_clr_sticky;
  logic                  w_holdoff_zero;

  assign w_pos          = r_s1_hi & ~r_s2_hi;
  assign w_neg          = ~r_s1_lo & r_s2_lo;
  assign w_holdoff_zero = (holdoff == '0);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_qual[i] = ch_cfg[5*i+0]
                       | (ch_cfg[5*i+1] & ~r_s2_lo[i])
                       | (ch_cfg[5*i+2] &  r_s2_hi[i])
                       | (ch_cfg[5*i+3] &  r_neg_sticky[i])
                       | (ch_cfg[5*i+4] &  r_pos_sticky[i]);
    end
  endgenerate

  // An unconfigured channel has qualify 0, so in AND mode it blocks the trigger.
  assign w_combined = combine_and ? (&w_qual) : (|w_qual);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_fire       = 1'b0;
    w_clr_sticky = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (armed) begin
          w_load = 1'b1;
          w_next = w_holdoff_zero ? S_WAIT : S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt <= c_one) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_combined) begin
          w_fire = 1'b1;
          w_next = S_TRIGGERED;
        end
      end
      S_TRIGGERED: begin
        if (trig_clr) begin
          w_load       = 1'b1;
          w_clr_sticky = 1'b1;
          w_next       = w_holdoff_zero ? S_WAIT : S_HOLDOFF;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Disarm wins over everything, including a simultaneous trig_clr.
    if (!armed) begin
      w_next       = S_IDLE;
      w_load       = 1'b0;
      w_fire       = 1'b0;
      w_clr_sticky = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hi      <= '0;
      r_s1_lo      <= '0;
      r_s2_hi      <= '0;
      r_s2_lo      <= '0;
      r_pos_sticky <= '0;
      r_neg_sticky <= '0;
      r_cnt        <= '0;
      trig_out     <= 1'b0;
      trig_pulse   <= 1'b0;
      trig_src     <= '0;
    end else begin
      r_s1_hi <= ch_hi;
      r_s1_lo <= ch_lo;
      r_s2_hi <= r_s1_hi;
      r_s2_lo <= r_s1_lo;

      if (w_load)                  r_cnt <= holdoff;
      else if (r_state == S_HOLDOFF) r_cnt <= r_cnt - c_one;

      if (w_clr_sticky) begin
        r_pos_sticky <= '0;
        r_neg_sticky <= '0;
      end else if (r_state == S_WAIT) begin
        r_pos_sticky <= r_pos_sticky | w_pos;
        r_neg_sticky <= r_neg_sticky | w_neg;
      end

      trig_pulse <= w_fire;
      if (w_clr_sticky) trig_out <= 1'b0;
      else if (w_fire)  trig_out <= 1'b1;
      if (w_fire) trig_src <= w_qual;
    end
  end

  assign busy = (r_state == S_HOLDOFF);

endmodule
`default_nettype wire

// File: tb/tb_multi_chan_trigger.sv
`default_nettype none
// tb_multi_chan_trigger: directed scenario tasks for multi_chan_trigger (NUM_CH=4).
module tb_multi_chan_trigger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        armed;
  logic [3:0]  ch_hi, ch_lo;
  logic [19:0] ch_cfg;
  logic        combine_and;
  logic [15:0] holdoff;
  logic        trig_clr;
  logic        trig_out, trig_pulse, busy;
  logic [3:0]  trig_src;

  int n_pass  = 0;
  int n_total = 0;

  multi_chan_trigger #(.NUM_CH(4), .HOLDOFF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .armed(armed), .ch_hi(ch_hi), .ch_lo(ch_lo),
    .ch_cfg(ch_cfg), .combine_and(combine_and), .holdoff(holdoff),
    .trig_clr(trig_clr), .trig_out(trig_out), .trig_pulse(trig_pulse),
    .trig_src(trig_src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input logic [4:0] c0, input logic [4:0] c1,
                         input logic [4:0] c2, input logic [4:0] c3);
    ch_cfg = {c3, c2, c1, c0};
  endtask

  task automatic test_reset;
    rst_n = 1'b1; armed = 1'b0; ch_hi = '0; ch_lo = '0; ch_cfg = '0;
    combine_and = 1'b0; holdoff = '0; trig_clr = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_total++; if (trig_out !== 1'b0) $display("FAIL reset_trig_out got=%b exp=0", trig_out); else n_pass++;
    n_total++; if (trig_pulse !== 1'b0) $display("FAIL reset_trig_pulse got=%b exp=0", trig_pulse); else n_pass++;
    n_total++; if (trig_src !== 4'b0000) $display("FAIL reset_trig_src got=%b exp=0000", trig_src); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    holdoff = 16'd3; armed = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    n_total++; if (busy !== 1'b1) $display("FAIL arm_after_reset_busy got=%b exp=1", busy); else n_pass++;
    armed = 1'b0;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL disarm_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_pos_edge;
    int pulses;
    set_cfg(5'b10000, 5'b00000, 5'b00000, 5'b00000);
    combine_and = 1'b0; holdoff = 16'd0; ch_hi = '0; ch_lo = '0;
    tick(3);
    armed = 1'b1;
    tick();
    ch_hi[0] = 1'b1;
    tick();
    n_total++; if (trig_out !== 1'b0) $display("FAIL pos_e0_trig_out got=%b exp=0", trig_out); else n_pass++;
    tick();
    n_total++; if (trig_out !== 1'b0) $display("FAIL pos_e1_trig_out got=%b exp=0", trig_out); else n_pass++;
    tick();
    n_total++; if (trig_out !== 1'b1) $display("FAIL pos_e2_trig_out got=%b exp=1", trig_out); else n_pass++;
    n_total++; if (trig_pulse !== 1'b1) $display("FAIL pos_e2_trig_pulse got=%b exp=1", trig_pulse); else n_pass++;
    n_total++; if (trig_src !== 4'b0001) $display("FAIL pos_trig_src got=%b exp=0001", trig_src); else n_pass++;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      ch_hi[0] = k[0];
      tick();
      if (trig_pulse === 1'b1) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL no_repulse_in_triggered got=%0d exp=0", pulses); else n_pass++;
    n_total++; if (trig_out !== 1'b1) $display("FAIL trig_out_sticky got=%b exp=1", trig_out); else n_pass++;
    armed = 1'b0;
    tick();
    n_total++; if (trig_out !== 1'b0) $display("FAIL disarm_trig_out got=%b exp=0", trig_out); else n_pass++;
    n_total++; if (trig_src !== 4'b0001) $display("FAIL trig_src_held got=%b exp=0001", trig_src); else n_pass++;
  endtask

  task automatic test_holdoff;
    int busy_cnt;
    set_cfg(5'b00000, 5'b00100, 5'b00000, 5'b00000);
    combine_and = 1'b0; holdoff = 16'd5; ch_hi = 4'b0010; ch_lo = '0;
    tick(3);
    armed = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 1) holdoff = 16'd2;
      if (busy !== 1'b1) break;
      busy_cnt++;
    end
    n_total++; if (busy_cnt !== 5) $display("FAIL holdoff_busy_cycles got=%0d exp=5", busy_cnt); else n_pass++;
    n_total++; if (trig_out !== 1'b0) $display("FAIL holdoff_wait_entry_trig got=%b exp=0", trig_out); else n_pass++;
    tick();
    n_total++; if (trig_out !== 1'b1) $display("FAIL holdoff_level_trig got=%b exp=1", trig_out); else n_pass++;
    n_total++; if (trig_src !== 4'b0010) $display("FAIL holdoff_trig_src got=%b exp=0010", trig_src); else n_pass++;
    armed = 1'b0;
    tick();
  endtask

  task automatic test_and_mode;
    set_cfg(5'b00100, 5'b00001, 5'b01000, 5'b00001);
    combine_and = 1'b1; holdoff = 16'd0; ch_hi = 4'b0001; ch_lo = 4'b0100;
    tick(3);
    armed = 1'b1;
    tick(5);
    n_total++; if (trig_out !== 1'b0) $display("FAIL and_partial_no_trig got=%b exp=0", trig_out); else n_pass++;
    ch_lo[2] = 1'b0;
    tick(2);
    n_total++; if (trig_out !== 1'b0) $display("FAIL and_e1_trig_out got=%b exp=0", trig_out); else n_pass++;
    tick();
    n_total++; if (trig_out !== 1'b1) $display("FAIL and_e2_trig_out got=%b exp=1", trig_out); else n_pass++;
    n_total++; if (trig_src !== 4'b1111) $display("FAIL and_trig_src got=%b exp=1111", trig_src); else n_pass++;
    armed = 1'b0; combine_and = 1'b0;
    tick();
  endtask

  task automatic test_holdoff_edge;
    bit timed_out;
    set_cfg(5'b10000, 5'b00000, 5'b00000, 5'b00000);
    holdoff = 16'd4; ch_hi = '0; ch_lo = '0;
    tick(3);
    armed = 1'b1;
    tick();
    ch_hi[0] = 1'b1;
    timed_out = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy === 1'b0) begin timed_out = 1'b0; break; end
    end
    n_total++; if (timed_out) $display("FAIL holdoff_edge_wait_timeout got=busy exp=wait"); else n_pass++;
    tick(3);
    n_total++; if (trig_out !== 1'b0) $display("FAIL holdoff_edge_not_captured got=%b exp=0", trig_out); else n_pass++;
    ch_hi[0] = 1'b0;
    tick(2);
    ch_hi[0] = 1'b1;
    tick(2);
    n_total++; if (trig_out !== 1'b0) $display("FAIL wait_edge_e1 got=%b exp=0", trig_out); else n_pass++;
    tick();
    n_total++; if (trig_out !== 1'b1) $display("FAIL wait_edge_trig got=%b exp=1", trig_out); else n_pass++;
  endtask

  task automatic test_clr_disarm;
    int busy_cnt;
    trig_clr = 1'b1; armed = 1'b0;
    tick();
    trig_clr = 1'b0;
    n_total++; if (trig_out !== 1'b0) $display("FAIL clr_disarm_trig_out got=%b exp=0", trig_out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL clr_disarm_busy got=%b exp=0", busy); else n_pass++;
    set_cfg(5'b00000, 5'b00100, 5'b00000, 5'b00000);
    holdoff = 16'd0; ch_hi = 4'b0010;
    tick(3);
    armed = 1'b1;
    tick(2);
    n_total++; if (trig_out !== 1'b1) $display("FAIL rearm_level_trig got=%b exp=1", trig_out); else n_pass++;
    holdoff = 16'd3; trig_clr = 1'b1;
    tick();
    trig_clr = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL clr_reload_busy got=%b exp=1", busy); else n_pass++;
    n_total++; if (trig_out !== 1'b0) $display("FAIL clr_trig_out got=%b exp=0", trig_out); else n_pass++;
    n_total++; if (trig_src !== 4'b0010) $display("FAIL clr_trig_src_held got=%b exp=0010", trig_src); else n_pass++;
    busy_cnt = 1;
    for (int k = 0; k < 20; k++) begin
      trig_clr = (k == 0);
      tick();
      if (busy !== 1'b1) break;
      busy_cnt++;
    end
    trig_clr = 1'b0;
    n_total++; if (busy_cnt !== 3) $display("FAIL clr_holdoff_cycles got=%0d exp=3", busy_cnt); else n_pass++;
    tick();
    n_total++; if (trig_pulse !== 1'b1) $display("FAIL retrigger_pulse got=%b exp=1", trig_pulse); else n_pass++;
    armed = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    holdoff = 16'd10; armed = 1'b1;
    tick(3);
    n_total++; if (busy !== 1'b1) $display("FAIL pre_reset_busy got=%b exp=1", busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL async_reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (trig_src !== 4'b0000) $display("FAIL async_reset_trig_src got=%b exp=0000", trig_src); else n_pass++;
    n_total++; if (trig_out !== 1'b0 || trig_pulse !== 1'b0)
      $display("FAIL async_reset_trig got=%b%b exp=00", trig_out, trig_pulse); else n_pass++;
    armed = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pos_edge();
    test_holdoff();
    test_and_mode();
    test_holdoff_edge();
    test_clr_disarm();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
